dma_send_queues: RTL and testbench

Buffers outbound DMA work from the core's DMA issue logic and presents it to the packet sender as three independent pop-on-request queues: read requests (16-bit host address), tile writes (16-bit host address plus 288-bit tile), and end-of-program notifications. Queued data is held stable after each pop, so the packet sender can sample it several cycles later. The end-program queue is ordering-gated so a notification is never offered while earlier read or write work is still buffered.

---
 rtl/dma_pkg.sv | 16 +
 rtl/pop_latch_fifo.sv | 80 ++++++++
 rtl/dma_send_queues.sv | 105 ++++++++++
 tb/tb_dma_send_queues.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA constants: host address width, tile width and default queue depths
// used by the outbound DMA send queues.
package dma_pkg;

    localparam int DMA_ADDR_BITS     = 16;
    localparam int DMA_TILE_BITS     = 18 * 16;
    localparam int DMA_RD_DEPTH_DEF  = 8;
    localparam int DMA_WR_DEPTH_DEF  = 4;
    localparam int DMA_END_DEPTH_DEF = 2;

    // Number of pointer bits for a power-of-two queue depth.
    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pop_latch_fifo.sv
// Circular-buffer queue whose output register loads only on an accepted pop and
// then holds, so the consumer may sample popped data several cycles later.
module pop_latch_fifo
    import dma_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    output logic                      full,
    input  logic                      pop,
    output logic                      available,
    output logic [WIDTH-1:0]          data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = ptr_bits(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic [WIDTH-1:0] data_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign empty_s   = (count_r == (AW+1)'(0));
    // A push is judged against the registered count, so a same-cycle pop never frees room.
    assign push_ok_s = push & ~full_s;
    assign pop_ok_s  = pop & ~empty_s;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Entry storage; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and the pop-latched output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            data_r   <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                data_r   <= mem_r[rd_ptr_r];
            end
            count_r <= count_next_s;
        end
    end

    assign full      = full_s;
    assign available = ~empty_s;
    assign data      = data_r;
    assign count     = count_r;

endmodule

// File: rtl/dma_send_queues.sv
// Outbound DMA work queues (read requests, tile writes, end-of-program) feeding
// the packet sender; end-of-program is withheld until read/write work drains.
module dma_send_queues
    import dma_pkg::*;
#(
    parameter int RD_DEPTH  = DMA_RD_DEPTH_DEF,
    parameter int WR_DEPTH  = DMA_WR_DEPTH_DEF,
    parameter int END_DEPTH = DMA_END_DEPTH_DEF,
    parameter int TILE_BITS = DMA_TILE_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rd_push,
    input  logic [DMA_ADDR_BITS-1:0]  rd_push_addr,
    output logic                      rd_full,
    input  logic                      wr_push,
    input  logic [DMA_ADDR_BITS-1:0]  wr_push_addr,
    input  logic [TILE_BITS-1:0]      wr_push_tile,
    output logic                      wr_full,
    input  logic                      end_push,
    output logic                      end_full,
    output logic [DMA_ADDR_BITS-1:0]  dma_send_read_queue_data,
    output logic                      dma_send_read_queue_available,
    input  logic                      dma_send_read_queue_re,
    output logic [DMA_ADDR_BITS-1:0]  dma_send_write_queue_data,
    output logic [TILE_BITS-1:0]      dma_send_write_queue_data2,
    output logic                      dma_send_write_queue_available,
    input  logic                      dma_send_write_queue_re,
    output logic                      dma_send_end_program_queue_available,
    input  logic                      dma_send_end_program_queue_re
);

    localparam int WR_WIDTH = DMA_ADDR_BITS + TILE_BITS;

    logic [$clog2(RD_DEPTH):0]  rd_count_s;
    logic [$clog2(WR_DEPTH):0]  wr_count_s;
    logic [$clog2(END_DEPTH):0] end_count_unused_s;
    logic [WR_WIDTH-1:0]        wr_data_s;
    logic [0:0]                 end_data_unused_s;
    logic                       end_nonempty_s;
    logic                       end_gate_s;

    pop_latch_fifo #(
        .WIDTH (DMA_ADDR_BITS),
        .DEPTH (RD_DEPTH)
    ) u_rd_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_push),
        .push_data (rd_push_addr),
        .full      (rd_full),
        .pop       (dma_send_read_queue_re),
        .available (dma_send_read_queue_available),
        .data      (dma_send_read_queue_data),
        .count     (rd_count_s)
    );

    pop_latch_fifo #(
        .WIDTH (WR_WIDTH),
        .DEPTH (WR_DEPTH)
    ) u_wr_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_push),
        .push_data ({wr_push_addr, wr_push_tile}),
        .full      (wr_full),
        .pop       (dma_send_write_queue_re),
        .available (dma_send_write_queue_available),
        .data      (wr_data_s),
        .count     (wr_count_s)
    );

    // The end queue only carries a token, so its payload is a constant bit.
    pop_latch_fifo #(
        .WIDTH (1),
        .DEPTH (END_DEPTH)
    ) u_end_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (end_push),
        .push_data (1'b1),
        .full      (end_full),
        .pop       (dma_send_end_program_queue_re),
        .available (end_nonempty_s),
        .data      (end_data_unused_s),
        .count     (end_count_unused_s)
    );

    assign dma_send_write_queue_data  = wr_data_s[WR_WIDTH-1:TILE_BITS];
    assign dma_send_write_queue_data2 = wr_data_s[TILE_BITS-1:0];

    // Ordering gate: also blocks on same-cycle read/write pushes so the notification
    // can never overtake work that is just being enqueued.
    always_comb begin
        end_gate_s = 1'b0;
        if ((rd_count_s == '0) && (wr_count_s == '0) && !rd_push && !wr_push) begin
            end_gate_s = end_nonempty_s;
        end else begin
            end_gate_s = 1'b0;
        end
    end

    assign dma_send_end_program_queue_available = end_gate_s;

endmodule

// File: tb/tb_dma_send_queues.sv
// Self-checking bench for dma_send_queues: vector table plus scoreboard model.
module tb_dma_send_queues;

    logic         clk;
    logic         reset;
    logic         rd_push;
    logic [15:0]  rd_push_addr;
    logic         rd_full;
    logic         wr_push;
    logic [15:0]  wr_push_addr;
    logic [287:0] wr_push_tile;
    logic         wr_full;
    logic         end_push;
    logic         end_full;
    logic [15:0]  rd_data;
    logic         rd_avail;
    logic         rd_re;
    logic [15:0]  wr_data;
    logic [287:0] wr_data2;
    logic         wr_avail;
    logic         wr_re;
    logic         end_avail;
    logic         end_re;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0]  rd_sb[$];
    logic [303:0] wr_sb[$];
    int           end_cnt;
    logic [15:0]  m_rd_data;
    logic [303:0] m_wr_data;

    dma_send_queues dut (
        .clk                                  (clk),
        .reset                                (reset),
        .rd_push                              (rd_push),
        .rd_push_addr                         (rd_push_addr),
        .rd_full                              (rd_full),
        .wr_push                              (wr_push),
        .wr_push_addr                         (wr_push_addr),
        .wr_push_tile                         (wr_push_tile),
        .wr_full                              (wr_full),
        .end_push                             (end_push),
        .end_full                             (end_full),
        .dma_send_read_queue_data             (rd_data),
        .dma_send_read_queue_available        (rd_avail),
        .dma_send_read_queue_re               (rd_re),
        .dma_send_write_queue_data            (wr_data),
        .dma_send_write_queue_data2           (wr_data2),
        .dma_send_write_queue_available       (wr_avail),
        .dma_send_write_queue_re              (wr_re),
        .dma_send_end_program_queue_available (end_avail),
        .dma_send_end_program_queue_re        (end_re)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [303:0] act, input logic [303:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [287:0] tile_of(input logic [15:0] a);
        return {18{a ^ 16'h5A5A}};
    endfunction

    task automatic model_clear();
        rd_sb.delete();
        wr_sb.delete();
        end_cnt   = 0;
        m_rd_data = 16'h0000;
        m_wr_data = '0;
    endtask

    task automatic check_outputs(input string tag);
        logic exp_end;
        exp_end = (end_cnt != 0) && (rd_sb.size() == 0) && (wr_sb.size() == 0);
        check({tag, "_rd_data"},   rd_data,           m_rd_data);
        check({tag, "_rd_avail"},  rd_avail,          rd_sb.size() != 0);
        check({tag, "_rd_full"},   rd_full,           rd_sb.size() == 8);
        check({tag, "_wr_data"},   wr_data,           m_wr_data[303:288]);
        check({tag, "_wr_tile"},   wr_data2,          m_wr_data[287:0]);
        check({tag, "_wr_avail"},  wr_avail,          wr_sb.size() != 0);
        check({tag, "_wr_full"},   wr_full,           wr_sb.size() == 4);
        check({tag, "_end_full"},  end_full,          end_cnt == 2);
        check({tag, "_end_avail"}, end_avail,         exp_end);
    endtask

    // One clock cycle of stimulus; model updated from pre-edge occupancy.
    task automatic step(input string tag, input logic rp, input logic [15:0] ra, input logic rre,
                        input logic wp, input logic [15:0] wa, input logic wre,
                        input logic ep, input logic ere);
        bit rd_pop_ok, wr_pop_ok, end_pop_ok, rd_push_ok, wr_push_ok, end_push_ok;
        rd_push = rp;  rd_push_addr = ra;  rd_re = rre;
        wr_push = wp;  wr_push_addr = wa;  wr_push_tile = tile_of(wa);  wr_re = wre;
        end_push = ep; end_re = ere;
        rd_push_ok  = rp  && (rd_sb.size() < 8);
        rd_pop_ok   = rre && (rd_sb.size() != 0);
        wr_push_ok  = wp  && (wr_sb.size() < 4);
        wr_pop_ok   = wre && (wr_sb.size() != 0);
        end_push_ok = ep  && (end_cnt < 2);
        end_pop_ok  = ere && (end_cnt != 0);
        if (rd_pop_ok)   m_rd_data = rd_sb.pop_front();
        if (rd_push_ok)  rd_sb.push_back(ra);
        if (wr_pop_ok)   m_wr_data = wr_sb.pop_front();
        if (wr_push_ok)  wr_sb.push_back({wa, tile_of(wa)});
        if (end_pop_ok)  end_cnt--;
        if (end_push_ok) end_cnt++;
        @(posedge clk);
        #1;
        rd_push = 1'b0; rd_re = 1'b0; wr_push = 1'b0; wr_re = 1'b0;
        end_push = 1'b0; end_re = 1'b0;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        check_outputs(tag);
    endtask

    typedef struct {
        logic        rp;
        logic [15:0] ra;
        logic        rre;
        logic        wp;
        logic [15:0] wa;
        logic        wre;
        logic        ep;
        logic        ere;
        logic        exp_rd_avail;
        logic [15:0] exp_rd_data;
        logic        exp_wr_avail;
        logic [15:0] exp_wr_data;
        logic        exp_end_avail;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hA001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hA002, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 16'h0000, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 16'hA001, 1'b0};
        vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 16'hA002, 1'b1};
        vecs[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 16'hA002, 1'b0};
        vecs[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 16'hA002, 1'b0};

        reset = 1'b1;
        rd_push = 1'b0; rd_push_addr = 16'h0000; rd_re = 1'b0;
        wr_push = 1'b0; wr_push_addr = 16'h0000; wr_push_tile = '0; wr_re = 1'b0;
        end_push = 1'b0; end_re = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs("rst");

        // Table-driven basic traffic with hand-computed expectations
        for (int i = 0; i < 10; i++) begin
            step($sformatf("tbl%0d", i), vecs[i].rp, vecs[i].ra, vecs[i].rre,
                 vecs[i].wp, vecs[i].wa, vecs[i].wre, vecs[i].ep, vecs[i].ere);
            check($sformatf("tbl%0d_rd_avail_c", i),  rd_avail,  vecs[i].exp_rd_avail);
            check($sformatf("tbl%0d_rd_data_c", i),   rd_data,   vecs[i].exp_rd_data);
            check($sformatf("tbl%0d_wr_avail_c", i),  wr_avail,  vecs[i].exp_wr_avail);
            check($sformatf("tbl%0d_wr_data_c", i),   wr_data,   vecs[i].exp_wr_data);
            check($sformatf("tbl%0d_end_avail_c", i), end_avail, vecs[i].exp_end_avail);
        end
        check("pop_empty_rd_data", rd_data, 16'h1234);

        // Popped read data is held across idle cycles
        for (int i = 0; i < 10; i++) begin
            step("hold", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        end

        // Fill to full, drop an extra push, drain in order
        for (int i = 1; i <= 8; i++) begin
            step("fill", 1'b1, 16'(i), 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        end
        check("rd_full_at_8", rd_full, 1'b1);
        step("drop9", 1'b1, 16'h0009, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step("drain", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
            check("drain_order", rd_data, 16'(i));
        end
        check("rd_empty_after_drain", rd_avail, 1'b0);

        // Streaming across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            step("wrap", 1'b1, 16'h0100 + 16'(i), (i % 3) != 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        end
        while (rd_sb.size() != 0) begin
            step("wrap_drain", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        end
        check("wrap_last", rd_data, 16'h0113);

        // Simultaneous push/pop on the write queue, partial and full
        step("wpp_a", 1'b0, 16'h0000, 1'b0, 1'b1, 16'hB001, 1'b0, 1'b0, 1'b0);
        step("wpp_b", 1'b0, 16'h0000, 1'b0, 1'b1, 16'hB002, 1'b0, 1'b0, 1'b0);
        step("wpp_pp", 1'b0, 16'h0000, 1'b0, 1'b1, 16'hB003, 1'b1, 1'b0, 1'b0);
        check("wpp_oldest_tile", wr_data2, tile_of(16'hB001));
        step("wpp_fill", 1'b0, 16'h0000, 1'b0, 1'b1, 16'hB004, 1'b0, 1'b0, 1'b0);
        step("wpp_fill2", 1'b0, 16'h0000, 1'b0, 1'b1, 16'hB005, 1'b0, 1'b0, 1'b0);
        check("wr_full_at_4", wr_full, 1'b1);
        step("wpp_full_pp", 1'b0, 16'h0000, 1'b0, 1'b1, 16'hB006, 1'b1, 1'b0, 1'b0);
        check("wr_not_full_after", wr_full, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("wpp_drain", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        end
        check("wpp_last_addr", wr_data, 16'hB005);
        check("wpp_empty", wr_avail, 1'b0);

        // End gating: same-cycle write push withholds the notification
        step("eg_end", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("eg_avail_idle", end_avail, 1'b1);
        wr_push = 1'b1; wr_push_addr = 16'hC001; wr_push_tile = tile_of(16'hC001);
        rd_push = 1'b0;
        #1;
        check("eg_wr_push_gate", end_avail, 1'b0);
        wr_push = 1'b0;
        rd_push = 1'b1;
        #1;
        check("eg_rd_push_gate", end_avail, 1'b0);
        rd_push = 1'b0;
        #1;
        check("eg_released", end_avail, 1'b1);
        step("eg_wr", 1'b0, 16'h0000, 1'b0, 1'b1, 16'hC001, 1'b0, 1'b0, 1'b0);
        check("eg_blocked_by_wr", end_avail, 1'b0);
        step("eg_wr_pop", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("eg_after_pop", end_avail, 1'b1);
        step("eg_end_pop", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Reset with work queued, then fresh traffic
        for (int i = 0; i < 3; i++) begin
            step("pre_rst_rd", 1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        end
        step("pre_rst_wr", 1'b0, 16'h0000, 1'b0, 1'b1, 16'hE001, 1'b0, 1'b1, 1'b0);
        do_reset("mid_rst");
        check("mid_rst_rd_data", rd_data, 16'h0000);
        check("mid_rst_wr_avail", wr_avail, 1'b0);
        step("post_rst_push", 1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step("post_rst_pop", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("post_rst_data", rd_data, 16'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
